// File: rtl/sort_pkg.sv
// Shared definitions for the streaming sorter front end: controller states and pad value.
package sort_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned PAD_MAX_BITS = 64;

  // Pads must sort to the tail: all-ones for ascending, zero for descending.
  function automatic logic [PAD_MAX_BITS-1:0] pad_value(input int unsigned value_bits,
                                                        input bit          direction);
    logic [PAD_MAX_BITS-1:0] p;
    p = '0;
    if (!direction) begin
      for (int unsigned i = 0; i < PAD_MAX_BITS; i++) begin
        if (i < value_bits) p[i] = 1'b1;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sort_stream_frontend.sv
// Stream-to-vector adapter around an external fixed-latency sorter: collects a batch,
// holds it on sort_in for the sorter latency, then streams the sorted result back out.
module sort_stream_frontend
  import sort_pkg::*;
#(
  parameter  int unsigned VALUE_BITS   = 8,
  parameter  int unsigned DEPTH        = 2,
  parameter  int unsigned DIRECTION    = 0,
  parameter  int unsigned SORT_LATENCY = 55,
  localparam int unsigned SIZE         = 1 << DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [VALUE_BITS-1:0]      in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [VALUE_BITS-1:0]      out_data,
  output logic                       out_last,
  output logic [SIZE*VALUE_BITS-1:0] sort_in,
  input  logic [SIZE*VALUE_BITS-1:0] sort_out,
  output logic                       busy
);

  localparam int unsigned TIMER_W = $clog2(SORT_LATENCY + 1);
  localparam logic [VALUE_BITS-1:0] PAD = VALUE_BITS'(pad_value(VALUE_BITS, DIRECTION != 0));
  localparam logic [SIZE-1:0][VALUE_BITS-1:0] PAD_VEC = {SIZE{PAD}};

  state_e                           state_q, state_d;
  logic [DEPTH-1:0]                 cnt_q, cnt_d;
  logic [DEPTH:0]                   n_q, n_d;
  logic [DEPTH-1:0]                 idx_q, idx_d;
  logic [TIMER_W-1:0]               timer_q, timer_d;
  logic [SIZE-1:0][VALUE_BITS-1:0]  buf_q, buf_d;
  logic [SIZE-1:0][VALUE_BITS-1:0]  res_q, res_d;
  logic                             last_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      buf_q   <= PAD_VEC;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      buf_q   <= buf_d;
      res_q   <= res_d;
    end
  end

  assign last_out = ({1'b0, idx_q} == (n_q - (DEPTH+1)'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    buf_d   = buf_q;
    res_d   = res_q;

    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          buf_d[cnt_q] = in_data;
          if (cnt_q == DEPTH'(SIZE - 1) || in_last) begin
            n_d     = {1'b0, cnt_q} + (DEPTH+1)'(1);
            cnt_d   = '0;
            timer_d = '0;
            state_d = SORT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      SORT: begin
        timer_d = timer_q + 1'b1;
        // sort_in has been stable since the first SORT cycle, so the sorter output
        // reflects this batch once SORT_LATENCY edges have passed.
        if (timer_q == TIMER_W'(SORT_LATENCY)) begin
          res_d   = sort_out;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (out_ready) begin
          if (last_out) begin
            buf_d   = PAD_VEC;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = FILL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  assign sort_in   = buf_q;
  assign in_ready  = (state_q == FILL);
  assign busy      = (state_q != FILL);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && last_out;
  assign out_data  = (state_q == DRAIN) ? res_q[idx_q] : '0;

endmodule

// File: tb/tb_sort_stream_frontend.sv
// Bench for sort_stream_frontend: ascending and descending instances, each with a
// behavioural fixed-latency sorter attached, checked against a queue-sort reference.
module tb_sort_stream_frontend;

  localparam int VW    = 8;
  localparam int DEPTH = 2;
  localparam int SIZE  = 4;
  localparam int LAT   = 6;

  typedef int vals_t [SIZE];
  typedef struct {
    int    d;
    int    n;
    vals_t v;
    vals_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]         in_valid, in_ready, in_last, out_valid, out_ready, out_last, busy;
  logic [VW-1:0]      in_data  [2];
  logic [VW-1:0]      out_data [2];
  logic [SIZE*VW-1:0] sort_in  [2];
  logic [SIZE*VW-1:0] sort_out [2];

  sort_stream_frontend #(.VALUE_BITS(VW), .DEPTH(DEPTH), .DIRECTION(0), .SORT_LATENCY(LAT)) dut_asc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
    .sort_in(sort_in[0]), .sort_out(sort_out[0]), .busy(busy[0])
  );

  sort_stream_frontend #(.VALUE_BITS(VW), .DEPTH(DEPTH), .DIRECTION(1), .SORT_LATENCY(LAT)) dut_desc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
    .sort_in(sort_in[1]), .sort_out(sort_out[1]), .busy(busy[1])
  );

  function automatic logic [SIZE*VW-1:0] net_sort(input logic [SIZE*VW-1:0] v, input bit desc);
    logic [VW-1:0]      e [SIZE];
    logic [VW-1:0]      t;
    logic [SIZE*VW-1:0] r;
    for (int i = 0; i < SIZE; i++) e[i] = v[i*VW +: VW];
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE-1; j++)
        if (desc ? (e[j] < e[j+1]) : (e[j] > e[j+1])) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    for (int i = 0; i < SIZE; i++) r[i*VW +: VW] = e[i];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_sorter
    logic [SIZE*VW-1:0] pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= net_sort(sort_in[g], g == 1);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign sort_out[g] = pipe[LAT-1];
  end

  int total = 0;
  int bad   = 0;
  int got  [$];
  int gotl [$];
  int first_acc, first_valid, last_cyc;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pad_of(input int d);
    return (d == 1) ? 0 : 255;
  endfunction

  // Called at a negedge; returns at the negedge after the last element is accepted.
  task automatic send_batch(input int d, input int n, input vals_t vals, input int gaps);
    int guard;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gaps)) begin
        in_valid[d] = 1'b0;
        in_data[d]  = VW'($urandom);
        in_last[d]  = 1'($urandom);
        @(negedge clk);
      end
      in_valid[d] = 1'b1;
      in_data[d]  = VW'(vals[i]);
      in_last[d]  = (i == n - 1);
      guard = 0;
      while (!in_ready[d] && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
      if (i == 0) first_acc = cyc;
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic recv(input int d, input int mode);
    int p = 0, pd = 0, pl = 0, stab = 0, blk = 0;
    bit stall = 0, done = 0;
    got.delete();
    gotl.delete();
    first_valid = -1;
    for (int g = 0; g < 400 && !done; g++) begin
      case (mode)
        0:       out_ready[d] = 1'b1;
        1:       out_ready[d] = (p % 3 == 0);
        default: out_ready[d] = 1'($urandom_range(0, 1));
      endcase
      if (out_valid[d]) begin
        if (first_valid < 0) first_valid = cyc;
        if (in_ready[d] || !busy[d]) blk++;
        if (stall && (int'(out_data[d]) != pd || int'(out_last[d]) != pl)) stab++;
        stall = !out_ready[d];
        pd = out_data[d];
        pl = out_last[d];
        p++;
        if (out_ready[d]) begin
          got.push_back(out_data[d]);
          gotl.push_back(out_last[d]);
          if (out_last[d]) begin
            done = 1;
            last_cyc = cyc;
          end
        end
      end
      @(negedge clk);
    end
    out_ready[d] = 1'b0;
    if (!done) chk("recv_timeout", 0, 1);
    else begin
      chk("out_valid_after_last", out_valid[d], 0);
      chk("in_ready_after_last", in_ready[d], 1);
    end
    chk("out_stable_on_stall", stab, 0);
    chk("in_blocked_while_draining", blk, 0);
  endtask

  task automatic cmp(input string tag, input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk({tag, "_data"}, got[i], exp[i]);
      chk({tag, "_last"}, gotl[i], int'(i == exp.size() - 1));
    end
  endtask

  vec_t  tbl [6];
  vals_t v;
  int    ex [$];
  int    q  [$];
  int    seen;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{d: 0, n: 4, v: '{9, 3, 7, 1},     e: '{1, 3, 7, 9}};
    tbl[1] = '{d: 0, n: 2, v: '{200, 5, 0, 0},   e: '{5, 200, 0, 0}};
    tbl[2] = '{d: 1, n: 4, v: '{4, 4, 0, 8},     e: '{8, 4, 4, 0}};
    tbl[3] = '{d: 1, n: 1, v: '{7, 0, 0, 0},     e: '{7, 0, 0, 0}};
    tbl[4] = '{d: 0, n: 3, v: '{10, 254, 0, 0},  e: '{0, 10, 254, 0}};
    tbl[5] = '{d: 1, n: 2, v: '{1, 255, 0, 0},   e: '{255, 1, 0, 0}};

    rst = 1'b1;
    in_valid = '0; in_last = '0; out_ready = '0;
    in_data[0] = '0; in_data[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", in_ready[d], 1);
      chk("reset_out_valid", out_valid[d], 0);
      chk("reset_out_last", out_last[d], 0);
      chk("reset_busy", busy[d], 0);
      chk("reset_out_data", out_data[d], 0);
      for (int i = 0; i < SIZE; i++) chk("reset_sort_in_pad", sort_in[d][i*VW +: VW], pad_of(d));
    end

    // Directed table: no gaps, no stalls, so turnaround is exact.
    for (int t = 0; t < 6; t++) begin
      int d, n;
      d = tbl[t].d;
      n = tbl[t].n;
      send_batch(d, n, tbl[t].v, 0);
      chk("busy_in_sort", busy[d], 1);
      chk("in_ready_in_sort", in_ready[d], 0);
      for (int i = 0; i < SIZE; i++)
        chk("sort_in_slot", sort_in[d][i*VW +: VW], (i < n) ? tbl[t].v[i] : pad_of(d));
      recv(d, 0);
      chk("turnaround", first_valid - first_acc, n + LAT + 1);
      ex.delete();
      for (int i = 0; i < n; i++) ex.push_back(tbl[t].e[i]);
      cmp("vec", ex);
    end

    // Backpressure 1,0,0,1,... during drain.
    v = '{9, 3, 7, 1};
    send_batch(0, 4, v, 0);
    recv(0, 1);
    ex = '{1, 3, 7, 9};
    cmp("stall", ex);

    // Reset during SORT: batch discarded, nothing emitted.
    send_batch(0, 4, v, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_sort_out_valid", out_valid[0], 0);
    chk("rst_sort_in_ready", in_ready[0], 1);
    chk("rst_sort_busy", busy[0], 0);
    seen = 0;
    repeat (LAT + 8) begin
      if (out_valid[0]) seen++;
      @(negedge clk);
    end
    chk("rst_sort_no_output", seen, 0);

    // Reset during DRAIN after one output; small stale values would leak if slots kept them.
    v = '{0, 1, 0, 0};
    send_batch(0, 4, v, 0);
    seen = 0;
    while (!out_valid[0] && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    chk("rst_drain_reached", out_valid[0], 1);
    chk("rst_drain_first_data", out_data[0], 0);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("rst_drain_still_valid", out_valid[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_drain_out_valid", out_valid[0], 0);
    chk("rst_drain_in_ready", in_ready[0], 1);
    v = '{2, 1, 0, 0};
    send_batch(0, 2, v, 0);
    recv(0, 0);
    ex = '{1, 2};
    cmp("after_rst", ex);

    // Back-to-back: second batch offered while the first drains.
    v = '{1, 2, 3, 4};
    send_batch(0, 4, v, 0);
    fork
      recv(0, 1);
      begin
        vals_t v2;
        v2 = '{100, 50, 0, 0};
        send_batch(0, 2, v2, 0);
      end
    join
    chk("b2b_accept_after_last", int'(first_acc > last_cyc), 1);
    ex = '{1, 2, 3, 4};
    cmp("b2b_first", ex);
    recv(0, 0);
    ex = '{50, 100};
    cmp("b2b_second", ex);

    // Random batches against queue-sort reference.
    for (int r = 0; r < 40; r++) begin
      int d, n;
      d = $urandom_range(0, 1);
      n = $urandom_range(1, SIZE);
      q.delete();
      for (int i = 0; i < SIZE; i++) begin
        v[i] = (d == 1) ? $urandom_range(1, 255) : $urandom_range(0, 254);
        if (i < n) q.push_back(v[i]);
      end
      if (d == 1) q.rsort();
      else        q.sort();
      send_batch(d, n, v, 2);
      recv(d, 2);
      cmp("rand", q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_stream_frontend.md
Name: sort_stream_frontend

Overview:
- Streaming host-side adapter for the pipelined bitonic sorter.
- Collects up to SIZE elements from a valid/ready input stream into a parallel vector and drives that vector into an external sorter instance.
- Waits the sorter's fixed pipeline latency, captures the result, and streams it back out serially with valid/ready/last.
- Pads short batches so pad slots sort to the tail; pads are never emitted.

Parameters:
- VALUE_BITS, 8, element width.
- DEPTH, 2, log2 of batch size.
- SIZE, 1 << DEPTH, batch size. Derived; never overridden.
- DIRECTION, 0, 0 = ascending, 1 = descending. Must match the attached sorter.
- SORT_LATENCY, 55, clock edges from sort_in to sort_out on the attached sorter. Must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts an input element.
- in_data  in  VALUE_BITS  input element.
- in_last  in  1  final element of the batch. Meaningful only with in_valid.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts the output element.
- out_data  out  VALUE_BITS  sorted element.
- out_last  out  1  final element of the sorted batch.
- sort_in  out  SIZE*VALUE_BITS  vector to the sorter. Element i is at bits [i*VALUE_BITS +: VALUE_BITS].
- sort_out  in  SIZE*VALUE_BITS  vector from the sorter, same packing.
- busy  out  1  high in SORT and DRAIN.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- PAD value: all-ones when DIRECTION=0, zero when DIRECTION=1, so pads always sort to the highest indices.
- Reset: state=FILL; in_ready=1; out_valid=0; out_last=0; busy=0; fill count=0; drain index=0; every buffer slot=PAD; out_data=0. A reset mid-batch discards the batch; no partial output.
- FILL: in_ready=1. On in_valid&in_ready, write in_data to slot[cnt] and increment cnt.
  - If cnt==SIZE-1 or in_last: latch n=cnt+1 (range 1..SIZE), then go to SORT next cycle.
  - in_last on the SIZE-th element is a single transition, not two.
- SORT: in_ready=0, busy=1. Timer starts at 0 on the first SORT cycle and increments each cycle.
  - sort_in is driven continuously from the fill buffer and held stable for the whole of SORT.
  - On the edge where timer==SORT_LATENCY, capture sort_out into the result buffer, reset the drain index to 0, and go to DRAIN.
  - SORT therefore lasts exactly SORT_LATENCY+1 cycles.
- DRAIN: out_valid=1, out_data=result[idx], out_last=(idx==n-1).
  - out_data and out_last hold stable while out_valid & ~out_ready.
  - On handshake, increment idx. On the handshake with out_last: out_valid=0 next cycle, all fill slots reset to PAD, cnt=0, go to FILL.
  - Input is blocked (in_ready=0) until then.
- Minimum turnaround: first input accept to first output valid = (n-1) + 1 + SORT_LATENCY + 1 cycles with no stalls. A full batch with in_valid constant takes SIZE fill cycles.
- sort_in is registered; it may change only in FILL.
- in_data/in_last are ignored when in_valid=0. in_valid in SORT/DRAIN is not accepted and has no effect.
- Duplicate values are allowed; relative order among equal values is unspecified.
- Input stream elements must not equal PAD, except where the pad position does not matter (caller contract, not checked).

Decomposition:
- Shared package sort_pkg: state enum (FILL, SORT, DRAIN); a function returning the pad value from VALUE_BITS and DIRECTION.
- The sorter is instantiated alongside by the integrator, not inside this block, so any sorter variant with a fixed latency can attach.
- No further sub-module. Counters and the FSM live in one module.

Test Plan:
- Full batch: DEPTH=2, DIRECTION=0, SORT_LATENCY matched to the sorter. Inputs 9,3,7,1 with last on 1 → outputs 1,3,7,9, out_last on 9. in_ready=0 from the cycle after the 4th accept until after the last output.
- Short batch: inputs 200,5 with last on 5 → exactly two outputs 5,200, out_last on 200. No 255 pads emitted.
- Descending: DIRECTION=1, inputs 4,4,0,8 → outputs 8,4,4,0. Short batch 7 → output 7 alone with out_last.
- Backpressure: out_ready toggles 1,0,0,1,… during drain → out_data/out_last stable across stalls, full sequence delivered once, no drops or repeats.
- Reset mid-operation: assert rst during SORT, then during DRAIN after one output → out_valid=0 next cycle, in_ready=1. A following batch 2,1 → outputs 1,2 only.
- Back-to-back batches: second batch presented while the first drains → not accepted until the first out_last handshake. Second batch is sorted correctly and its pads do not leak stale first-batch values.
